// File: rtl/hud_pkg.sv
// Shared types and constants for the health HUD renderer.
// Covers the health width, the icon colours and the flash FSM states.
package hud_pkg;
    localparam int HP_W = 2;
    localparam logic [HP_W-1:0] HP_MAX = 2'd3;
    localparam logic [23:0] FULL_RGB  = 24'hff2020;
    localparam logic [23:0] EMPTY_RGB = 24'h404040;

    typedef enum logic {IDLE, FLASH} state_t;
endpackage

// File: rtl/health_hud_renderer_if.sv
// Pixel-stream link between the VGA colour mapper (master) and the HUD renderer (slave).
interface health_hud_renderer_if;
    logic       vs_n;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       hud_on;
    logic [7:0] hud_red;
    logic [7:0] hud_green;
    logic [7:0] hud_blue;

    modport master (output vs_n, draw_x, draw_y,
                    input  hud_on, hud_red, hud_green, hud_blue);
    modport slave  (input  vs_n, draw_x, draw_y,
                    output hud_on, hud_red, hud_green, hud_blue);
endinterface

// File: rtl/hud_flash_fsm.sv
// Damage-flash controller: runs the flash length and blink phase, one step per frame tick.
module hud_flash_fsm
    import hud_pkg::*;
#(
    parameter int FLASH_FRAMES = 60,
    parameter int BLINK_FRAMES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic damage,
    output logic flashing,
    output logic blink_vis
);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES - 1);

    state_t     state, state_nxt;
    logic [7:0] flash_cnt, flash_nxt;
    logic [7:0] blink_cnt, blink_nxt;
    logic       vis_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            flash_cnt <= '0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else begin
            state     <= state_nxt;
            flash_cnt <= flash_nxt;
            blink_cnt <= blink_nxt;
            blink_vis <= vis_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flash_nxt = flash_cnt;
        blink_nxt = blink_cnt;
        vis_nxt   = blink_vis;
        if (tick) begin
            // A fresh hit always restarts the flash, whatever state we are in.
            if (damage) begin
                state_nxt = FLASH;
                flash_nxt = FLASH_LOAD;
                blink_nxt = BLINK_LOAD;
                vis_nxt   = 1'b0;
            end else if (state == FLASH) begin
                if (flash_cnt == '0) begin
                    state_nxt = IDLE;
                    vis_nxt   = 1'b1;
                end else begin
                    flash_nxt = flash_cnt - 8'd1;
                    if (blink_cnt == '0) begin
                        vis_nxt   = ~blink_vis;
                        blink_nxt = BLINK_LOAD;
                    end else begin
                        blink_nxt = blink_cnt - 8'd1;
                    end
                end
            end
        end
    end

    assign flashing = (state == FLASH);
endmodule

// File: rtl/health_hud_renderer.sv
// Health HUD renderer: frame-sampled health, icon hit-test and registered pixel output.
module health_hud_renderer
    import hud_pkg::*;
#(
    parameter int HUD_X        = 16,
    parameter int HUD_Y        = 16,
    parameter int ICON_W       = 16,
    parameter int ICON_H       = 8,
    parameter int ICON_GAP     = 4,
    parameter int FLASH_FRAMES = 60,
    parameter int BLINK_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [HP_W-1:0]         health,
    health_hud_renderer_if.slave    pix,
    output logic                    game_over,
    output logic                    flashing
);
    localparam logic [10:0] Y_LO = 11'(HUD_Y);
    localparam logic [10:0] Y_HI = 11'(HUD_Y + ICON_H);

    function automatic logic [10:0] icon_lo(input int i);
        return 11'(HUD_X + i * (ICON_W + ICON_GAP));
    endfunction

    logic            vs_n_d;
    logic [HP_W-1:0] hp_frame;
    logic            tick;
    logic            damage;
    logic            blink_vis;

    assign tick   = vs_n_d & ~pix.vs_n;
    assign damage = tick && (health < hp_frame);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_n_d   <= 1'b1;
            hp_frame <= HP_MAX;
        end else begin
            vs_n_d <= pix.vs_n;
            if (tick) hp_frame <= health;
        end
    end

    assign game_over = (hp_frame == '0);

    hud_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_flash (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .damage    (damage),
        .flashing  (flashing),
        .blink_vis (blink_vis)
    );

    // Stage p0: combinational icon hit-test on the current coordinates
    logic [10:0] x_p0, y_p0;
    logic        on_p0;
    logic [23:0] rgb_p0;

    always_comb begin
        x_p0   = {1'b0, pix.draw_x};
        y_p0   = {1'b0, pix.draw_y};
        on_p0  = 1'b0;
        rgb_p0 = '0;
        if (y_p0 >= Y_LO && y_p0 < Y_HI) begin
            for (int i = 0; i < 3; i++) begin
                if (x_p0 >= icon_lo(i) && x_p0 < icon_lo(i) + 11'(ICON_W)) begin
                    if (i < int'(hp_frame)) begin
                        if (blink_vis) begin
                            on_p0  = 1'b1;
                            rgb_p0 = FULL_RGB;
                        end
                    end else begin
                        on_p0  = 1'b1;
                        rgb_p0 = EMPTY_RGB;
                    end
                end
            end
        end
    end

    // Stage p1: registered HUD pixel, one clock behind draw_x/draw_y
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix.hud_on    <= 1'b0;
            pix.hud_red   <= '0;
            pix.hud_green <= '0;
            pix.hud_blue  <= '0;
        end else begin
            pix.hud_on    <= on_p0;
            pix.hud_red   <= rgb_p0[23:16];
            pix.hud_green <= rgb_p0[15:8];
            pix.hud_blue  <= rgb_p0[7:0];
        end
    end
endmodule

// File: tb/tb_health_hud_renderer.sv
// Scoreboard bench for health_hud_renderer: pixel expectations are queued at drive time.
module tb_health_hud_renderer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] health = 2'd3;
    logic       game_over;
    logic       flashing;

    health_hud_renderer_if hif();

    health_hud_renderer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .health    (health),
        .pix       (hif),
        .game_over (game_over),
        .flashing  (flashing)
    );

    initial forever #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        pix_vld = 1'b0;
    logic        vld_d = 1'b0;
    logic [24:0] sb[$];
    logic [24:0] mon_e;
    int          exp_hp = 3;
    bit          exp_vis = 1'b1;

    int px[13] = '{16, 31, 32, 36, 51, 56, 71, 72, 15, 16, 16, 60, 1023};
    int py[13] = '{16, 23, 16, 20, 16, 16, 23, 16, 16, 15, 24, 24, 1023};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {hud_on, rgb}: icons at x 16..31, 36..51, 56..71 and y 16..23.
    function automatic logic [24:0] model(input int x, input int y, input int hp, input bit vis);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (x >= 16 + 20 * i && x <= 31 + 20 * i && y >= 16 && y <= 23) begin
                if (i >= hp)  r = {1'b1, 24'h404040};
                else if (vis) r = {1'b1, 24'hff2020};
            end
        end
        return r;
    endfunction

    always @(posedge clk) vld_d <= pix_vld;

    always @(negedge clk) begin
        if (vld_d) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else begin
                mon_e = sb.pop_front();
                chk("pixel", {7'd0, hif.hud_on, hif.hud_red, hif.hud_green, hif.hud_blue}, {7'd0, mon_e});
            end
        end
    end

    task automatic pix(input int x, input int y);
        @(posedge clk); #1;
        hif.draw_x = 10'(x);
        hif.draw_y = 10'(y);
        pix_vld    = 1'b1;
        sb.push_back(model(x, y, exp_hp, exp_vis));
    endtask

    task automatic drain();
        @(posedge clk); #1;
        pix_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic scan();
        for (int k = 0; k < 13; k++) pix(px[k], py[k]);
        drain();
    endtask

    task automatic frame_tick();
        @(posedge clk); #1;
        hif.vs_n = 1'b0;
        @(posedge clk); #1;
        hif.vs_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hif.vs_n   = 1'b1;
        hif.draw_x = '0;
        hif.draw_y = '0;

        // 1: reset state, then all three icons FULL
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hud_on", hif.hud_on, 1'b0);
        chk("rst_rgb", {hif.hud_red, hif.hud_green, hif.hud_blue}, 24'h0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_flashing", flashing, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_hp = 3; exp_vis = 1'b1;
        scan();
        chk("t1_game_over", game_over, 1'b0);

        // 2: mid-frame change is invisible until the next tick
        health = 2'd2;
        scan();
        chk("t2_no_flash_yet", flashing, 1'b0);
        frame_tick();
        chk("t2_flashing", flashing, 1'b1);
        exp_hp = 2; exp_vis = 1'b0;
        scan();

        // 3: blink phases of four frames, flash ends after 60 ticks
        for (int n = 1; n <= 60; n++) begin
            exp_vis = (((n - 1) / 4) % 2) == 1;
            pix(16, 16); pix(36, 16); pix(56, 16);
            drain();
            chk("t3_flashing", flashing, 1'b1);
            frame_tick();
        end
        chk("t3_flash_end", flashing, 1'b0);
        exp_vis = 1'b1;
        scan();

        // 4: second hit at tick 30 restarts the flash
        health = 2'd3;
        frame_tick();
        chk("t4_heal_no_flash", flashing, 1'b0);
        health = 2'd2;
        frame_tick();
        chk("t4_first_hit", flashing, 1'b1);
        for (int t = 1; t <= 29; t++) frame_tick();
        health = 2'd1;
        frame_tick();
        exp_hp = 1; exp_vis = 1'b0;
        pix(16, 16); pix(36, 16); pix(56, 16);
        drain();
        for (int t = 1; t <= 60; t++) begin
            frame_tick();
            chk($sformatf("t4_restart_%0d", t), flashing, 32'(t < 60));
        end

        // 5: game over one clock after the tick, healing clears it without a flash
        health = 2'd0;
        @(posedge clk); #1;
        hif.vs_n = 1'b0;
        @(negedge clk);
        chk("t5_go_before", game_over, 1'b0);
        @(posedge clk); #1;
        hif.vs_n = 1'b1;
        @(negedge clk);
        chk("t5_go_after", game_over, 1'b1);
        exp_hp = 0; exp_vis = 1'b0;
        scan();
        chk("t5_flashing", flashing, 1'b1);
        for (int t = 1; t <= 60; t++) frame_tick();
        chk("t5_flash_done", flashing, 1'b0);
        health = 2'd3;
        frame_tick();
        chk("t5_go_clear", game_over, 1'b0);
        chk("t5_no_flash", flashing, 1'b0);
        exp_hp = 3; exp_vis = 1'b1;
        scan();

        // 6: asynchronous reset in the middle of a flash
        health = 2'd0;
        frame_tick();
        hif.draw_x = 10'd16;
        hif.draw_y = 10'd16;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_hud_on", hif.hud_on, 1'b1);
        chk("t6_pre_go", game_over, 1'b1);
        chk("t6_pre_flash", flashing, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_hud_on", hif.hud_on, 1'b0);
        chk("t6_rst_flash", flashing, 1'b0);
        chk("t6_rst_go", game_over, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        health  = 2'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_idle", flashing, 1'b0);
        frame_tick();
        chk("t6_idle_tick", flashing, 1'b0);
        exp_hp = 3; exp_vis = 1'b1;
        scan();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
